// File: rtl/spi_master_ctrl.sv
// SPI master: fetches packed {ss, rd, size, addr, wdata} words and runs one framed transfer per word.
// Optional build macro SPI_LOOPBACK_EN feeds MOSI back as MISO internally.
module spi_master_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int SSWIDTH = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                master_en,
  input  logic [SSWIDTH+3+AWIDTH+DWIDTH-1:0]  driver_data,
  input  logic [1:0]                          driver_cfg,
  output logic                                driver_read,
  output logic                                sclk,
  output logic                                mosi,
  input  logic                                miso,
  output logic [2**SSWIDTH-1:0]               ss_n,
  output logic [DWIDTH-1:0]                   rd_data,
  output logic                                rd_valid
);
  localparam int NSLV = 2**SSWIDTH;
  localparam int HDR  = 3 + AWIDTH;
  localparam int FW   = HDR + DWIDTH;
  localparam int ECW  = $clog2(2*FW + 1);
  localparam int DVW  = $clog2(CLK_DIV);
  localparam int NBW  = $clog2(DWIDTH + 1);
  localparam logic [DVW-1:0] DLAST = DVW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  logic [DVW-1:0]    div;
  logic [ECW-1:0]    ecnt, etot;
  logic [FW-1:0]     sh;
  logic [DWIDTH-1:0] rx;
  logic [1:0]        cfg;
  logic              rd_op;
  logic              miso_i;

  logic [SSWIDTH-1:0] ss_f;
  logic               rd_f;
  logic [1:0]         size_f;
  int                 nb_raw;
  logic [NBW-1:0]     nbits_in;
  logic [DWIDTH-1:0]  wdata_al;
  logic [FW-1:0]      frame_in;
  logic [ECW-1:0]     etot_in;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign miso_i      = mosi;
`else
  assign miso_i = miso;
`endif

  assign ss_f   = driver_data[SSWIDTH+HDR+DWIDTH-1 -: SSWIDTH];
  assign rd_f   = driver_data[HDR+DWIDTH-1];
  assign size_f = driver_data[HDR+DWIDTH-2 -: 2];

  always_comb begin
    nb_raw = DWIDTH;
    case (size_f)
      2'b00:   nb_raw = 8;
      2'b01:   nb_raw = 16;
      2'b10:   nb_raw = 32;
      default: nb_raw = DWIDTH;
    endcase
    nbits_in = NBW'((nb_raw > DWIDTH) ? DWIDTH : nb_raw);
  end

  // Data field left-aligned so the frame always shifts out from the top bit.
  assign wdata_al = driver_data[DWIDTH-1:0] << (DWIDTH - int'(nbits_in));
  assign frame_in = {driver_data[HDR+DWIDTH-1:DWIDTH], wdata_al};
  assign etot_in  = ECW'(2*(HDR + int'(nbits_in)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      ecnt        <= '0;
      etot        <= '0;
      sh          <= '0;
      rx          <= '0;
      cfg         <= 2'b00;
      rd_op       <= 1'b0;
      driver_read <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      ss_n        <= '1;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      driver_read <= 1'b0;
      rd_valid    <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= driver_cfg[1];
          div  <= '0;
          if (master_en) begin
            driver_read <= 1'b1;
            cfg         <= driver_cfg;
            rd_op       <= rd_f;
            etot        <= etot_in;
            ecnt        <= '0;
            rx          <= '0;
            ss_n        <= ~(NSLV'(1) << ss_f);
            // CPHA=0 needs the first bit on the wire before the leading edge.
            if (driver_cfg[0]) begin
              sh <= frame_in;
            end else begin
              mosi <= frame_in[FW-1];
              sh   <= frame_in << 1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div == DLAST) begin
            div   <= '0;
            state <= SHIFT;
          end else div <= div + DVW'(1);
        end
        SHIFT: begin
          if (div == DLAST) begin
            div  <= '0;
            sclk <= ~sclk;
            ecnt <= ecnt + ECW'(1);
            // Even edge count = leading edge; sample edge is leading for CPHA=0, trailing for CPHA=1.
            if (ecnt[0] == cfg[0]) begin
              if (ecnt >= ECW'(2*HDR)) rx <= {rx[DWIDTH-2:0], miso_i};
            end else begin
              mosi <= sh[FW-1];
              sh   <= sh << 1;
            end
            if (ecnt == etot - ECW'(1)) state <= HOLD;
          end else div <= div + DVW'(1);
        end
        HOLD: begin
          sclk <= cfg[1];
          if (div == DLAST) begin
            div  <= '0;
            ss_n <= '1;
            if (rd_op) begin
              rd_data  <= rx;
              rd_valid <= 1'b1;
            end
            state <= GAP;
          end else div <= div + DVW'(1);
        end
        GAP: begin
          if (div == DLAST) begin
            div   <= '0;
            state <= IDLE;
          end else div <= div + DVW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised scoreboard bench for spi_master_ctrl: frame-level SPI slave model plus read-data queue.
module tb_spi_master_ctrl;
  localparam int DW = 32, AW = 8, SSW = 2, CD = 2, HDR = 3 + AW;

  logic clk = 1'b0;
  logic rst, master_en, driver_read, sclk, mosi, rd_valid;
  logic miso = 1'b0;
  logic [SSW+3+AW+DW-1:0] driver_data;
  logic [1:0]  driver_cfg;
  logic [3:0]  ss_n;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .SSWIDTH(SSW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .master_en(master_en), .driver_data(driver_data),
    .driver_cfg(driver_cfg), .driver_read(driver_read), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  typedef struct { logic [3:0] ssn; int n; logic [63:0] bits; } frame_t;
  frame_t      exp_q[$];
  logic [31:0] rd_q[$];
  int total = 0, bad = 0, issued = 0, dr_cnt = 0;
  logic [1:0]  pend_cfg = 2'b00;
  logic [31:0] pend_rdata = '0;
  int          pend_nb = 8;
  logic        abort_frame = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nbits_of(input logic [1:0] sz);
    int n;
    case (sz)
      2'b00: n = 8;
      2'b01: n = 16;
      2'b10: n = 32;
      default: n = DW;
    endcase
    return (n > DW) ? DW : n;
  endfunction

  // Present one instruction, wait for it to be fetched, then record what the wire should carry.
  task automatic issue(input logic [1:0] ss, input logic rd, input logic [1:0] sz,
                       input logic [7:0] addr, input logic [31:0] wd, input logic [1:0] cfg,
                       input logic keep, input logic [31:0] srd);
    frame_t f;
    int nb;
    logic got;
    logic [63:0] m;
    nb = nbits_of(sz);
    driver_data = {ss, rd, sz, addr, wd};
    driver_cfg  = cfg;
    pend_cfg    = cfg;
    pend_rdata  = srd;
    pend_nb     = nb;
    master_en   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (driver_read) got = 1'b1;
    end
    chk("fetch_pulse", got, 1);
    if (got) begin
      f.ssn  = ~(4'b0001 << ss);
      f.n    = HDR + nb;
      f.bits = '0;
      f.bits = {f.bits[62:0], rd};
      f.bits = {f.bits[62:0], sz[1]};
      f.bits = {f.bits[62:0], sz[0]};
      for (int i = AW-1; i >= 0; i--) f.bits = {f.bits[62:0], addr[i]};
      for (int i = nb-1; i >= 0; i--) f.bits = {f.bits[62:0], wd[i]};
      exp_q.push_back(f);
      m = (64'd1 << nb) - 64'd1;
      if (rd) begin
`ifdef SPI_LOOPBACK_EN
        rd_q.push_back(wd & m[31:0]);
`else
        rd_q.push_back(srd & m[31:0]);
`endif
      end
      issued++;
    end
    if (!keep) master_en = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("frames_drained", exp_q.size() + rd_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) if (driver_read) dr_cnt++;

  // Read-data monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_valid_unexpected", rd_valid, 0);
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end

  // Slave model: drives MISO, samples MOSI on its sampling edge, checks each frame at ss_n release.
  logic sel;
  assign sel = (ss_n != 4'hF);
  logic sel_q = 1'b0, sclk_q = 1'b0, have_prev = 1'b0, lead;
  logic [1:0] fr_cfg = 2'b00;
  logic [3:0] ss_seen;
  longint t_start = 0, t_end = 0;
  int pulses = 0, obs_n = 0;
  logic [63:0] obs;
  bit sq[$];
  frame_t e;

  always @(sclk or sel) begin
    if (sel && !sel_q) begin
      fr_cfg  = pend_cfg;
      ss_seen = ss_n;
      t_start = $time;
      pulses  = 0;
      obs     = '0;
      obs_n   = 0;
      sq.delete();
      for (int i = 0; i < HDR; i++) sq.push_back(bit'($urandom_range(0, 1)));
      for (int i = pend_nb-1; i >= 0; i--) sq.push_back(pend_rdata[i]);
      if (!fr_cfg[0]) miso = sq.pop_front();
      if (have_prev && !abort_frame) begin
        total++;
        if ((t_start - t_end)/10 < CD+1) begin
          bad++;
          $display("FAIL ss_gap: got %0d cycles expected >= %0d", (t_start - t_end)/10, CD+1);
        end
      end
    end else if (!sel && sel_q) begin
      if (!abort_frame) begin
        t_end = $time;
        have_prev = 1'b1;
        if (exp_q.size() == 0) chk("frame_unexpected", ss_n, 4'h0);
        else begin
          e = exp_q.pop_front();
          chk("ss_n_select", ss_seen, e.ssn);
          chk("sclk_pulses", pulses, e.n);
          chk("mosi_nbits", obs_n, e.n);
          chk("mosi_bits", obs, e.bits);
          chk("ss_low_cycles", (t_end - t_start)/10, CD*(2*e.n + 2));
        end
      end
    end else if (sel && sclk != sclk_q) begin
      lead = (sclk != fr_cfg[1]);
      if (lead || pulses > 0) begin
        if (lead) pulses++;
        if (lead != fr_cfg[0]) begin
          obs = {obs[62:0], mosi};
          obs_n++;
        end else if (sq.size() != 0) miso = sq.pop_front();
        else miso = 1'b0;
      end
    end
    sel_q  = sel;
    sclk_q = sclk;
  end

  int dr0;
  initial begin
    rst = 1'b1; master_en = 1'b0; driver_data = '0; driver_cfg = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_ss_n", ss_n, 4'hF);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_driver_read", driver_read, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    abort_frame = 1'b0;
    @(negedge clk);

    issue(2'b01, 1'b0, 2'b00, 8'hA5, 32'h0000_003C, 2'b00, 1'b0, $urandom);
    wait_idle();
    issue(2'b10, 1'b1, 2'b10, 8'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD_BEEF);
    wait_idle();
    chk("sclk_idle_cpol", sclk, 1);

    dr0 = dr_cnt;
    issue(2'b00, 1'b1, 2'b01, 8'h3C, $urandom, 2'b01, 1'b1, $urandom);
    issue(2'b11, 1'b0, 2'b11, 8'hC3, $urandom, 2'b10, 1'b1, $urandom);
    issue(2'b01, 1'b1, 2'b00, 8'h5A, $urandom, 2'b00, 1'b0, $urandom);
    wait_idle();
    chk("b2b_fetches", dr_cnt - dr0, 3);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] r;
      r = $urandom;
      issue(r[1:0], r[2], r[4:3], r[12:5], $urandom, r[14:13], (i != 19), $urandom);
    end
    wait_idle();
    chk("random_fetches", dr_cnt, issued);

    // Enable drops right after the fetch, so the 43-bit frame runs with master_en low.
    issue(2'b11, 1'b0, 2'b10, 8'h77, $urandom, 2'b00, 1'b0, $urandom);
    wait_idle();
    repeat (100) @(negedge clk);
    chk("no_fetch_while_disabled", dr_cnt, issued);

    issue(2'b00, 1'b1, 2'b10, 8'h01, 32'h1234_5678, 2'b01, 1'b0, $urandom);
    wait_idle();

    issue(2'b10, 1'b1, 2'b10, 8'h22, $urandom, 2'b00, 1'b0, 32'hCAFE_F00D);
    repeat (40) @(negedge clk);
    abort_frame = 1'b1;
    exp_q.delete();
    rd_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", ss_n, 4'hF);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_rd_valid", rd_valid, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_no_fetch", dr_cnt, issued);
    abort_frame = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
